// File: rtl/lin_rsp_chk.sv
// lin_rsp_chk: LIN response checker; forwards data bytes with index, accumulates the
// carry-wrap checksum and reports pass/fail. Define LIN_ENHANCED_CKS_EN for PID-seeded (LIN 2.x) checksum.
module lin_rsp_chk (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic [7:0] pid,
    input  logic [3:0] data_len,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_err,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic [2:0] dout_idx,
    output logic       busy,
    output logic       done,
    output logic       cks_ok,
    output logic       cks_err,
    output logic       frm_err,
    output logic [7:0] calc_cks
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned LEN_W  = 4;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(8);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_CKS  = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [BYTE_W-1:0] sum, sum_nxt;
    logic [IDX_W-1:0]  cnt, cnt_nxt;
    logic [LEN_W-1:0]  len, len_nxt;

    logic [BYTE_W-1:0] dout_nxt;
    logic              dout_valid_nxt;
    logic [IDX_W-1:0]  dout_idx_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              cks_ok_nxt;
    logic              cks_err_nxt;
    logic              frm_err_nxt;
    logic [BYTE_W-1:0] calc_cks_nxt;

    logic              in_frame;
    logic              bad_len;
    logic              last_byte;
    logic [BYTE_W-1:0] seed;
    logic [BYTE_W-1:0] sum_add;
    logic [BYTE_W-1:0] cks_exp;

    // 8-bit add with the carry folded back into bit 0
    function automatic logic [BYTE_W-1:0] wrap_add(input logic [BYTE_W-1:0] a,
                                                   input logic [BYTE_W-1:0] b);
        logic [BYTE_W:0] s;
        s = (BYTE_W+1)'(a) + (BYTE_W+1)'(b);
        return s[BYTE_W-1:0] + BYTE_W'(s[BYTE_W]);
    endfunction

    // Diagnostic frames (0x3C/0x3D) always use the classic checksum
    function automatic logic [BYTE_W-1:0] seed_of(input logic [BYTE_W-1:0] p);
`ifdef LIN_ENHANCED_CKS_EN
        return (p[5:0] == 6'h3C || p[5:0] == 6'h3D) ? BYTE_W'(0) : p;
`else
        return p & BYTE_W'(0);
`endif
    endfunction

    assign in_frame  = (state != ST_IDLE);
    assign bad_len   = (data_len == LEN_W'(0)) || (data_len > MAX_LEN);
    assign last_byte = ({1'b0, cnt} == (len - LEN_W'(1)));
    assign seed      = seed_of(pid);
    assign sum_add   = wrap_add(sum, rx_data);
    assign cks_exp   = ~sum;

    // Next-state and next-output logic; frame_start > rx_err > rx_valid
    always_comb begin
        state_nxt      = state;
        sum_nxt        = sum;
        cnt_nxt        = cnt;
        len_nxt        = len;
        dout_nxt       = dout;
        dout_valid_nxt = 1'b0;
        dout_idx_nxt   = dout_idx;
        done_nxt       = 1'b0;
        cks_ok_nxt     = cks_ok;
        cks_err_nxt    = cks_err;
        frm_err_nxt    = frm_err;
        calc_cks_nxt   = calc_cks;

        if (frame_start) begin
            // A restart aborts the running frame; its error shows until the next done
            done_nxt    = in_frame;
            frm_err_nxt = in_frame;
            cks_ok_nxt  = 1'b0;
            cks_err_nxt = 1'b0;
            if (bad_len) begin
                state_nxt   = ST_IDLE;
                done_nxt    = 1'b1;
                frm_err_nxt = 1'b1;
            end else begin
                state_nxt = ST_DATA;
                sum_nxt   = seed;
                cnt_nxt   = IDX_W'(0);
                len_nxt   = data_len;
            end
        end else if (rx_err && in_frame) begin
            state_nxt   = ST_IDLE;
            done_nxt    = 1'b1;
            frm_err_nxt = 1'b1;
        end else if (rx_valid) begin
            case (state)
                ST_DATA: begin
                    sum_nxt        = sum_add;
                    dout_nxt       = rx_data;
                    dout_idx_nxt   = cnt;
                    dout_valid_nxt = 1'b1;
                    cnt_nxt        = cnt + IDX_W'(1);
                    if (last_byte) begin
                        state_nxt = ST_CKS;
                    end
                end
                ST_CKS: begin
                    calc_cks_nxt = cks_exp;
                    cks_ok_nxt   = (rx_data == cks_exp);
                    cks_err_nxt  = (rx_data != cks_exp);
                    frm_err_nxt  = 1'b0;
                    done_nxt     = 1'b1;
                    state_nxt    = ST_IDLE;
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end

        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            sum        <= '0;
            cnt        <= '0;
            len        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_idx   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cks_ok     <= 1'b0;
            cks_err    <= 1'b0;
            frm_err    <= 1'b0;
            calc_cks   <= '0;
        end else begin
            state      <= state_nxt;
            sum        <= sum_nxt;
            cnt        <= cnt_nxt;
            len        <= len_nxt;
            dout       <= dout_nxt;
            dout_valid <= dout_valid_nxt;
            dout_idx   <= dout_idx_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            cks_ok     <= cks_ok_nxt;
            cks_err    <= cks_err_nxt;
            frm_err    <= frm_err_nxt;
            calc_cks   <= calc_cks_nxt;
        end
    end

endmodule

// File: tb/tb_lin_rsp_chk.sv
// Self-checking bench for lin_rsp_chk: directed vector table, corner sequences,
// and random traffic against a frame-level checksum model.
module tb_lin_rsp_chk;

    typedef struct packed {
        logic [7:0] dout;
        logic       dv;
        logic [2:0] idx;
        logic       busy;
        logic       done;
        logic       ok;
        logic       err;
        logic       fe;
        logic [7:0] calc;
    } obs_t;

    typedef struct {
        logic       fs;
        logic [7:0] pid;
        logic [3:0] len;
        logic       rv;
        logic [7:0] rd;
        logic       re;
        obs_t       exp;
    } vec_t;

`ifdef LIN_ENHANCED_CKS_EN
    localparam logic [7:0] CK = 8'hE6;
`else
    localparam logic [7:0] CK = 8'h31;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic [7:0] pid = '0;
    logic [3:0] data_len = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_err = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic [2:0] dout_idx;
    logic       busy;
    logic       done;
    logic       cks_ok;
    logic       cks_err;
    logic       frm_err;
    logic [7:0] calc_cks;

    int total = 0;
    int bad   = 0;

    lin_rsp_chk dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .pid(pid),
        .data_len(data_len), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
        .dout(dout), .dout_valid(dout_valid), .dout_idx(dout_idx), .busy(busy),
        .done(done), .cks_ok(cks_ok), .cks_err(cks_err), .frm_err(frm_err),
        .calc_cks(calc_cks)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    function automatic obs_t get_obs();
        return {dout, dout_valid, dout_idx, busy, done, cks_ok, cks_err, frm_err, calc_cks};
    endfunction

    function automatic obs_t ob(input logic [7:0] d, input logic v, input logic [2:0] i,
                                input logic b, input logic dn, input logic ok,
                                input logic er, input logic fe, input logic [7:0] c);
        return {d, v, i, b, dn, ok, er, fe, c};
    endfunction

    function automatic vec_t mk(input logic fs, input logic [7:0] p, input logic [3:0] l,
                                input logic rv, input logic [7:0] rd, input logic re,
                                input obs_t e);
        vec_t r;
        r.fs = fs; r.pid = p; r.len = l; r.rv = rv; r.rd = rd; r.re = re; r.exp = e;
        return r;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the rising edge
    task automatic cyc(input logic fs, input logic [7:0] p, input logic [3:0] l,
                       input logic v, input logic [7:0] d, input logic e);
        frame_start = fs; pid = p; data_len = l; rx_valid = v; rx_data = d; rx_err = e;
        @(posedge clk);
        #1;
        frame_start = 1'b0; rx_valid = 1'b0; rx_err = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        frame_start = 1'b0; rx_valid = 1'b0; rx_err = 1'b0;
        pid = '0; data_len = '0; rx_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", get_obs(), '0);
        reset_n = 1'b1;
    endtask

    // Frame-level model: ones'-complement sum kept as a plain integer total
    bit   m_open;
    int   m_got, m_want, m_total;
    obs_t m;

    function automatic logic [7:0] fold(input int t);
        if (t == 0) return 8'h00;
        return 8'(((t - 1) % 255) + 1);
    endfunction

    function automatic int seed_m(input logic [7:0] p);
        int s;
        s = int'(p);
`ifdef LIN_ENHANCED_CKS_EN
        if (p[5:0] == 6'h3C || p[5:0] == 6'h3D) s = 0;
`else
        s = 0;
`endif
        return s;
    endfunction

    function automatic void model_step(input logic fs, input logic [7:0] p, input logic [3:0] l,
                                       input logic v, input logic [7:0] d, input logic e);
        logic [7:0] c;
        m.dv = 1'b0;
        m.done = 1'b0;
        if (fs) begin
            m.done = m_open;
            m.fe = m_open;
            m.ok = 1'b0;
            m.err = 1'b0;
            if (l < 1 || l > 8) begin
                m_open = 0; m.done = 1'b1; m.fe = 1'b1;
            end else begin
                m_open = 1; m_got = 0; m_want = int'(l); m_total = seed_m(p);
            end
        end else if (e && m_open) begin
            m.fe = 1'b1; m.done = 1'b1; m_open = 0;
        end else if (v && m_open) begin
            if (m_got < m_want) begin
                m.dout = d; m.idx = 3'(m_got); m.dv = 1'b1;
                m_total += int'(d); m_got++;
            end else begin
                c = ~fold(m_total);
                m.calc = c; m.ok = (d == c); m.err = (d != c); m.fe = 1'b0;
                m.done = 1'b1; m_open = 0;
            end
        end
        m.busy = m_open;
    endfunction

    vec_t vt[$];

    initial begin
        // Directed table: frame 0x4A/55,93,E5, carry wrap, mismatch, bad len, rx_err, restart, priority
        vt.push_back(mk(1, 8'h4A, 4'd3, 0, 8'h00, 0, ob(8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00)));
        vt.push_back(mk(0, 8'h00, 4'd0, 1, 8'h55, 0, ob(8'h55, 1, 0, 1, 0, 0, 0, 0, 8'h00)));
        vt.push_back(mk(0, 8'h00, 4'd0, 1, 8'h93, 0, ob(8'h93, 1, 1, 1, 0, 0, 0, 0, 8'h00)));
        vt.push_back(mk(0, 8'h00, 4'd0, 1, 8'hE5, 0, ob(8'hE5, 1, 2, 1, 0, 0, 0, 0, 8'h00)));
        vt.push_back(mk(0, 8'h00, 4'd0, 0, 8'h00, 0, ob(8'hE5, 0, 2, 1, 0, 0, 0, 0, 8'h00)));
        vt.push_back(mk(0, 8'h00, 4'd0, 1, CK,    0, ob(8'hE5, 0, 2, 0, 1, 1, 0, 0, CK)));
        vt.push_back(mk(0, 8'h00, 4'd0, 0, 8'h00, 0, ob(8'hE5, 0, 2, 0, 0, 1, 0, 0, CK)));
        vt.push_back(mk(0, 8'h00, 4'd0, 1, 8'h12, 0, ob(8'hE5, 0, 2, 0, 0, 1, 0, 0, CK)));
        vt.push_back(mk(1, 8'h3C, 4'd2, 0, 8'h00, 0, ob(8'hE5, 0, 2, 1, 0, 0, 0, 0, CK)));
        vt.push_back(mk(0, 8'h00, 4'd0, 1, 8'hFF, 0, ob(8'hFF, 1, 0, 1, 0, 0, 0, 0, CK)));
        vt.push_back(mk(0, 8'h00, 4'd0, 1, 8'hFF, 0, ob(8'hFF, 1, 1, 1, 0, 0, 0, 0, CK)));
        vt.push_back(mk(0, 8'h00, 4'd0, 1, 8'h00, 0, ob(8'hFF, 0, 1, 0, 1, 1, 0, 0, 8'h00)));
        vt.push_back(mk(1, 8'h3C, 4'd1, 0, 8'h00, 0, ob(8'hFF, 0, 1, 1, 0, 0, 0, 0, 8'h00)));
        vt.push_back(mk(0, 8'h00, 4'd0, 1, 8'h10, 0, ob(8'h10, 1, 0, 1, 0, 0, 0, 0, 8'h00)));
        vt.push_back(mk(0, 8'h00, 4'd0, 1, 8'h00, 0, ob(8'h10, 0, 0, 0, 1, 0, 1, 0, 8'hEF)));
        vt.push_back(mk(1, 8'h3C, 4'd0, 0, 8'h00, 0, ob(8'h10, 0, 0, 0, 1, 0, 0, 1, 8'hEF)));
        vt.push_back(mk(0, 8'h00, 4'd0, 0, 8'h00, 0, ob(8'h10, 0, 0, 0, 0, 0, 0, 1, 8'hEF)));
        vt.push_back(mk(1, 8'h3C, 4'd9, 0, 8'h00, 0, ob(8'h10, 0, 0, 0, 1, 0, 0, 1, 8'hEF)));
        vt.push_back(mk(1, 8'h3C, 4'd4, 0, 8'h00, 0, ob(8'h10, 0, 0, 1, 0, 0, 0, 0, 8'hEF)));
        vt.push_back(mk(0, 8'h00, 4'd0, 1, 8'h01, 0, ob(8'h01, 1, 0, 1, 0, 0, 0, 0, 8'hEF)));
        vt.push_back(mk(0, 8'h00, 4'd0, 1, 8'h77, 1, ob(8'h01, 0, 0, 0, 1, 0, 0, 1, 8'hEF)));
        vt.push_back(mk(0, 8'h00, 4'd0, 1, 8'h22, 0, ob(8'h01, 0, 0, 0, 0, 0, 0, 1, 8'hEF)));
        vt.push_back(mk(1, 8'h3C, 4'd2, 0, 8'h00, 0, ob(8'h01, 0, 0, 1, 0, 0, 0, 0, 8'hEF)));
        vt.push_back(mk(0, 8'h00, 4'd0, 1, 8'h05, 0, ob(8'h05, 1, 0, 1, 0, 0, 0, 0, 8'hEF)));
        vt.push_back(mk(1, 8'h3C, 4'd1, 1, 8'h99, 0, ob(8'h05, 0, 0, 1, 1, 0, 0, 1, 8'hEF)));
        vt.push_back(mk(0, 8'h00, 4'd0, 1, 8'h07, 0, ob(8'h07, 1, 0, 1, 0, 0, 0, 1, 8'hEF)));
        vt.push_back(mk(0, 8'h00, 4'd0, 1, 8'hF8, 0, ob(8'h07, 0, 0, 0, 1, 1, 0, 0, 8'hF8)));
        vt.push_back(mk(1, 8'h3C, 4'd1, 0, 8'h00, 1, ob(8'h07, 0, 0, 1, 0, 0, 0, 0, 8'hF8)));
        vt.push_back(mk(0, 8'h00, 4'd0, 1, 8'h01, 0, ob(8'h01, 1, 0, 1, 0, 0, 0, 0, 8'hF8)));
        vt.push_back(mk(0, 8'h00, 4'd0, 1, 8'hFE, 0, ob(8'h01, 0, 0, 0, 1, 1, 0, 0, 8'hFE)));

        do_reset();

        foreach (vt[k]) begin
            cyc(vt[k].fs, vt[k].pid, vt[k].len, vt[k].rv, vt[k].rd, vt[k].re);
            check($sformatf("vec%0d", k), get_obs(), vt[k].exp);
        end

        // Diagnostic frame, eight bytes, classic checksum in either build
        cyc(1, 8'h3C, 4'd8, 0, 8'h00, 0);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 8'h00, 4'd0, 1, 8'h01, 0);
            check($sformatf("diag_byte%0d", k), get_obs(), ob(8'h01, 1, 3'(k), 1, 0, 0, 0, 0, 8'hFE));
        end
        cyc(0, 8'h00, 4'd0, 1, 8'hF7, 0);
        check("diag_cks", get_obs(), ob(8'h01, 0, 7, 0, 1, 1, 0, 0, 8'hF7));

        // Asynchronous reset in mid-frame: immediate clear, no done afterwards
        cyc(1, 8'h3C, 4'd4, 0, 8'h00, 0);
        cyc(0, 8'h00, 4'd0, 1, 8'h11, 0);
        cyc(0, 8'h00, 4'd0, 1, 8'h22, 0);
        check("pre_rst", get_obs(), ob(8'h22, 1, 1, 1, 0, 0, 0, 0, 8'hF7));
        #2 reset_n = 1'b0;
        #1 check("rst_async", get_obs(), '0);
        repeat (3) @(posedge clk);
        #1 check("rst_hold", get_obs(), '0);
        reset_n = 1'b1;
        cyc(1, 8'h3C, 4'd1, 0, 8'h00, 0);
        check("post_rst_start", get_obs(), ob(8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00));
        cyc(0, 8'h00, 4'd0, 1, 8'h40, 0);
        check("post_rst_byte", get_obs(), ob(8'h40, 1, 0, 1, 0, 0, 0, 0, 8'h00));
        cyc(0, 8'h00, 4'd0, 1, 8'hBF, 0);
        check("post_rst_cks", get_obs(), ob(8'h40, 0, 0, 0, 1, 1, 0, 0, 8'hBF));

        // Random traffic against the model
        do_reset();
        m = '0; m_open = 0; m_got = 0; m_want = 0; m_total = 0;
        for (int n = 0; n < 3000; n++) begin
            logic       fs, v, e;
            logic [7:0] p, d;
            logic [3:0] l;
            fs = ($urandom_range(0, 24) == 0);
            p = 8'($urandom);
            if ($urandom_range(0, 3) == 0) p[5:0] = ($urandom_range(0, 1) != 0) ? 6'h3C : 6'h3D;
            l = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(1, 8));
            v = ($urandom_range(0, 2) != 0);
            e = ($urandom_range(0, 59) == 0);
            d = 8'($urandom);
            if (m_open && m_got == m_want && $urandom_range(0, 1) != 0) d = ~fold(m_total);
            model_step(fs, p, l, v, d, e);
            cyc(fs, p, l, v, d, e);
            check($sformatf("rand%0d", n), get_obs(), m);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lin_rsp_chk.md
# lin_rsp_chk

Receive-side LIN response checker: consumes the byte stream that follows the PID from the LIN UART receiver, forwards data bytes with their index, accumulates the LIN carry-wrap checksum, and compares the result against the received checksum byte. It sits between the LIN byte receiver and the frame handler. It produces a one-cycle completion pulse with sticky pass/fail status.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse; latches pid/data_len, clears accumulator, enters DATA
- pid  in  8  protected identifier of current frame, sampled on frame_start
- data_len  in  4  number of data bytes, 1..8, sampled on frame_start
- rx_valid  in  1  one-cycle strobe, rx_data holds a received byte
- rx_data  in  8  received byte
- rx_err  in  1  framing/bit error from byte receiver, one-cycle strobe
- dout  out  8  registered copy of accepted data byte
- dout_valid  out  1  one-cycle pulse with dout
- dout_idx  out  3  index 0..7 of dout within the frame
- busy  out  1  high in DATA or CKS
- done  out  1  one-cycle pulse at frame end (ok, checksum error or frame error)
- cks_ok  out  1  sticky; checksum matched
- cks_err  out  1  sticky; checksum mismatch
- frm_err  out  1  sticky; rx_err, bad data_len, or restart while busy
- calc_cks  out  8  expected checksum (inverted sum), valid when done

## Operation
- States: IDLE, DATA, CKS.
- IDLE: rx_valid ignored. frame_start -> seed sum, cnt=0, clear cks_ok/cks_err/frm_err, go DATA. If data_len is 0 or >8: stay IDLE, done and frm_err asserted next cycle.
- DATA: each rx_valid -> sum update, dout/dout_idx=cnt, dout_valid pulse, cnt+1. After byte data_len-1 -> CKS.
- CKS: rx_valid -> calc_cks=~sum; cks_ok=(rx_data==~sum), cks_err=inverse; done pulse; go IDLE. Checksum byte not forwarded on dout.
- Sum arithmetic: 9-bit add s=sum+byte; sum_next = s[7:0]+s[8] (end-around carry). 8-bit result; 0xFF+0xFF yields 0xFF.
- rx_err in DATA or CKS: frm_err=1, done pulse, go IDLE; same-cycle rx_valid ignored.
- frame_start while busy: current frame aborted with frm_err=1 and done pulse, then new frame started in the same edge (status of new frame then cleared on first accepted byte? no: new frame status reflects abort until next done). Simultaneous rx_valid ignored.
- frame_start has priority over rx_err, rx_err over rx_valid.

## Timing
- Reset values: dout=0, dout_valid=0, dout_idx=0, busy=0, done=0, cks_ok=0, cks_err=0, frm_err=0, calc_cks=0; state IDLE, sum=0.
- All outputs registered; dout_valid and done one cycle after the causing strobe.
- busy rises the cycle after frame_start, falls with done.
- Back-to-back rx_valid every cycle supported; no stall path.
- Sticky status held until next frame_start.
- reset_n low mid-frame: immediate return to reset values, no done.

## Configuration
- LIN_ENHANCED_CKS_EN defined: on frame_start, sum seeded with pid (enhanced checksum, LIN 2.x), except when pid[5:0] is 0x3C or 0x3D (diagnostic frames), which seed 0.
- Undefined: sum always seeded 0 (classic checksum, LIN 1.x); pid latched but unused by arithmetic.

## Test plan
- Enhanced (macro on): pid=0x4A, len=3, bytes 0x55,0x93,0xE5, cks 0xE6 -> three dout_valid idx 0..2, done, cks_ok=1, calc_cks=0xE6.
- Classic (macro off): same data, cks 0x31 -> cks_ok=1; cks 0xE6 -> cks_err=1, calc_cks=0x31.
- Carry wrap: len=2, bytes 0xFF,0xFF, cks 0x00 -> cks_ok=1, calc_cks=0x00.
- Diagnostic with macro on: pid=0x3C, len=8, eight 0x01, cks 0xF7 -> cks_ok=1.
- rx_err after byte 1 of len=4 -> done next cycle, frm_err=1, busy=0, later rx_valid ignored; data_len=0 -> done, frm_err=1.
- reset_n low after byte 2 -> all outputs zero, no done; next frame_start processes normally.
